// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types for the DDR ARW arbiter.
//   arb_state_e   - arbiter FSM state (IDLE, BUSY)
//   ARB_IDX_W     - width of a master index (two masters)
//   ARB_MAX_ID_W  - widest master ID the payload struct can carry
//   arw_payload_t - one master's ARW payload (addr, id, len, size, burst, lock, write)
package ddr_arb_pkg;
   typedef enum logic {IDLE, BUSY} arb_state_e;
   localparam int ARB_IDX_W    = 1;
   localparam int ARB_MAX_ID_W = 32;
   typedef struct packed {
      logic [31:0]             addr;
      logic [ARB_MAX_ID_W-1:0] id;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
      logic [1:0]              lock;
      logic                    write;
   } arw_payload_t;
endpackage

// File: rtl/ddr_arb_order_fifo.sv
// ddr_arb_order_fifo: synchronous FIFO of master indices used as the write-order queue.
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   push_i, din_i   - enqueue a master index
//   pop_i, dout_o   - dequeue; dout_o shows the head entry
//   full_o, empty_o - occupancy flags
//   count_o         - number of stored entries
module ddr_arb_order_fifo
   import ddr_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [ARB_IDX_W-1:0]   din_i,
   input  logic                   pop_i,
   output logic [ARB_IDX_W-1:0]   dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [ARB_IDX_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wptr_q, rptr_q;
   logic [AW:0]          count_q;
   logic                 wr, rd;
   assign rd      = pop_i & ~empty_o;
   // a push into a full queue is accepted when the head leaves in the same cycle
   assign wr      = push_i & (~full_o | rd);
   assign full_o  = count_q == (AW+1)'(DEPTH);
   assign empty_o = count_q == '0;
   assign count_o = count_q;
   assign dout_o  = mem_q[rptr_q];
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr) wptr_q <= wptr_q + 1'b1;
         if (rd) rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
      end
   end
   always_ff @(posedge clk_i) begin
      if (wr) mem_q[wptr_q] <= din_i;
   end
endmodule

// File: rtl/ddr_axi_arw_arbiter.sv
// ddr_axi_arw_arbiter: shares one combined-ARW AXI port (io_ddrA_*) between two masters.
//   io_memoryClk, resetn - clock, asynchronous active-low reset
//   mN_arw_*             - master N address request (write flag selects read/write)
//   mN_w_*               - master N write data, forwarded in granted write-address order
//   mN_b_*, mN_r_*       - responses routed back by the response ID MSB
//   io_ddrA_*            - slave side; ARW ID = {grant, master id}, W ID = {queue head, 0}
// Build option: DDR_ARB_RR_EN selects round-robin arbitration, otherwise m0 has fixed priority.
module ddr_axi_arw_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int ID_WIDTH   = 8,
   parameter int DATA_WIDTH = 128,
   parameter int WQ_DEPTH   = 4
) (
   input  logic                    io_memoryClk,
   input  logic                    resetn,
   input  logic                    m0_arw_valid,
   output logic                    m0_arw_ready,
   input  logic [31:0]             m0_arw_addr,
   input  logic [ID_WIDTH-2:0]     m0_arw_id,
   input  logic [7:0]              m0_arw_len,
   input  logic [2:0]              m0_arw_size,
   input  logic [1:0]              m0_arw_burst,
   input  logic [1:0]              m0_arw_lock,
   input  logic                    m0_arw_write,
   input  logic                    m0_w_valid,
   output logic                    m0_w_ready,
   input  logic [DATA_WIDTH-1:0]   m0_w_data,
   input  logic [DATA_WIDTH/8-1:0] m0_w_strb,
   input  logic                    m0_w_last,
   output logic                    m0_b_valid,
   input  logic                    m0_b_ready,
   output logic [ID_WIDTH-2:0]     m0_b_id,
   output logic                    m0_r_valid,
   input  logic                    m0_r_ready,
   output logic [DATA_WIDTH-1:0]   m0_r_data,
   output logic [ID_WIDTH-2:0]     m0_r_id,
   output logic [1:0]              m0_r_resp,
   output logic                    m0_r_last,
   input  logic                    m1_arw_valid,
   output logic                    m1_arw_ready,
   input  logic [31:0]             m1_arw_addr,
   input  logic [ID_WIDTH-2:0]     m1_arw_id,
   input  logic [7:0]              m1_arw_len,
   input  logic [2:0]              m1_arw_size,
   input  logic [1:0]              m1_arw_burst,
   input  logic [1:0]              m1_arw_lock,
   input  logic                    m1_arw_write,
   input  logic                    m1_w_valid,
   output logic                    m1_w_ready,
   input  logic [DATA_WIDTH-1:0]   m1_w_data,
   input  logic [DATA_WIDTH/8-1:0] m1_w_strb,
   input  logic                    m1_w_last,
   output logic                    m1_b_valid,
   input  logic                    m1_b_ready,
   output logic [ID_WIDTH-2:0]     m1_b_id,
   output logic                    m1_r_valid,
   input  logic                    m1_r_ready,
   output logic [DATA_WIDTH-1:0]   m1_r_data,
   output logic [ID_WIDTH-2:0]     m1_r_id,
   output logic [1:0]              m1_r_resp,
   output logic                    m1_r_last,
   output logic                    io_ddrA_arw_valid,
   input  logic                    io_ddrA_arw_ready,
   output logic [31:0]             io_ddrA_arw_payload_addr,
   output logic [ID_WIDTH-1:0]     io_ddrA_arw_payload_id,
   output logic [7:0]              io_ddrA_arw_payload_len,
   output logic [2:0]              io_ddrA_arw_payload_size,
   output logic [1:0]              io_ddrA_arw_payload_burst,
   output logic [1:0]              io_ddrA_arw_payload_lock,
   output logic                    io_ddrA_arw_payload_write,
   output logic                    io_ddrA_w_valid,
   input  logic                    io_ddrA_w_ready,
   output logic [DATA_WIDTH-1:0]   io_ddrA_w_payload_data,
   output logic [DATA_WIDTH/8-1:0] io_ddrA_w_payload_strb,
   output logic                    io_ddrA_w_payload_last,
   output logic [ID_WIDTH-1:0]     io_ddrA_w_payload_id,
   input  logic                    io_ddrA_b_valid,
   output logic                    io_ddrA_b_ready,
   input  logic [ID_WIDTH-1:0]     io_ddrA_b_payload_id,
   input  logic                    io_ddrA_r_valid,
   output logic                    io_ddrA_r_ready,
   input  logic [DATA_WIDTH-1:0]   io_ddrA_r_payload_data,
   input  logic [ID_WIDTH-1:0]     io_ddrA_r_payload_id,
   input  logic [1:0]              io_ddrA_r_payload_resp,
   input  logic                    io_ddrA_r_payload_last
);
   arb_state_e                state_q;
   logic [ARB_IDX_W-1:0]      gnt_q, win, wq_head;
   arw_payload_t              m0_p, m1_p, sel_p;
   logic                      busy, arw_hs, m0_elig, m1_elig;
   logic                      wq_push, wq_pop, wq_full, wq_empty;
   logic [$clog2(WQ_DEPTH):0] wq_count;
   logic                      r_sel, b_sel, unused_bits;

   assign m0_p = '{addr: m0_arw_addr, id: ARB_MAX_ID_W'(m0_arw_id), len: m0_arw_len,
                   size: m0_arw_size, burst: m0_arw_burst, lock: m0_arw_lock, write: m0_arw_write};
   assign m1_p = '{addr: m1_arw_addr, id: ARB_MAX_ID_W'(m1_arw_id), len: m1_arw_len,
                   size: m1_arw_size, burst: m1_arw_burst, lock: m1_arw_lock, write: m1_arw_write};
   // the grant stays fixed until the handshake, so the live master payload is stable on the bus
   assign sel_p  = gnt_q[0] ? m1_p : m0_p;
   assign busy   = state_q == BUSY;
   assign arw_hs = busy & io_ddrA_arw_ready;

   // a write may only win while its slot in the write-order queue is guaranteed
   assign m0_elig = m0_arw_valid & (~m0_arw_write | ~wq_full);
   assign m1_elig = m1_arw_valid & (~m1_arw_write | ~wq_full);

`ifdef DDR_ARB_RR_EN
   logic ptr_q;
   assign win = (m0_elig & m1_elig) ? ptr_q : m1_elig;
   always_ff @(posedge io_memoryClk or negedge resetn) begin
      if (!resetn) ptr_q <= 1'b0;
      else if (arw_hs) ptr_q <= ~gnt_q[0];
   end
`else
   assign win = ~m0_elig;
`endif

   always_ff @(posedge io_memoryClk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         gnt_q   <= '0;
      end else if (state_q == IDLE) begin
         if (m0_elig | m1_elig) begin
            state_q <= BUSY;
            gnt_q   <= win;
         end
      end else if (io_ddrA_arw_ready) begin
         state_q <= IDLE;
      end
   end

   assign io_ddrA_arw_valid         = busy;
   assign io_ddrA_arw_payload_addr  = sel_p.addr;
   assign io_ddrA_arw_payload_id    = {gnt_q, sel_p.id[ID_WIDTH-2:0]};
   assign io_ddrA_arw_payload_len   = sel_p.len;
   assign io_ddrA_arw_payload_size  = sel_p.size;
   assign io_ddrA_arw_payload_burst = sel_p.burst;
   assign io_ddrA_arw_payload_lock  = sel_p.lock;
   assign io_ddrA_arw_payload_write = sel_p.write;
   assign m0_arw_ready              = arw_hs & ~gnt_q[0];
   assign m1_arw_ready              = arw_hs &  gnt_q[0];

   assign wq_push = arw_hs & sel_p.write;
   assign wq_pop  = io_ddrA_w_valid & io_ddrA_w_ready & io_ddrA_w_payload_last;

   ddr_arb_order_fifo #(.DEPTH(WQ_DEPTH)) u_wq (
      .clk_i   (io_memoryClk),
      .rst_ni  (resetn),
      .push_i  (wq_push),
      .din_i   (gnt_q),
      .pop_i   (wq_pop),
      .dout_o  (wq_head),
      .full_o  (wq_full),
      .empty_o (wq_empty),
      .count_o (wq_count)
   );

   // W follows the master at the queue head; early data from others simply waits
   assign io_ddrA_w_valid        = ~wq_empty & (wq_head[0] ? m1_w_valid : m0_w_valid);
   assign io_ddrA_w_payload_data = wq_head[0] ? m1_w_data : m0_w_data;
   assign io_ddrA_w_payload_strb = wq_head[0] ? m1_w_strb : m0_w_strb;
   assign io_ddrA_w_payload_last = wq_head[0] ? m1_w_last : m0_w_last;
   assign io_ddrA_w_payload_id   = {wq_head, {(ID_WIDTH-1){1'b0}}};
   assign m0_w_ready             = ~wq_empty & ~wq_head[0] & io_ddrA_w_ready;
   assign m1_w_ready             = ~wq_empty &  wq_head[0] & io_ddrA_w_ready;

   // response paths are combinational, so reset gating keeps them quiet while resetn is low
   assign r_sel           = io_ddrA_r_payload_id[ID_WIDTH-1];
   assign m0_r_valid      = resetn & io_ddrA_r_valid & ~r_sel;
   assign m1_r_valid      = resetn & io_ddrA_r_valid &  r_sel;
   assign io_ddrA_r_ready = resetn & (r_sel ? m1_r_ready : m0_r_ready);
   assign m0_r_data       = io_ddrA_r_payload_data;
   assign m1_r_data       = io_ddrA_r_payload_data;
   assign m0_r_id         = io_ddrA_r_payload_id[ID_WIDTH-2:0];
   assign m1_r_id         = io_ddrA_r_payload_id[ID_WIDTH-2:0];
   assign m0_r_resp       = io_ddrA_r_payload_resp;
   assign m1_r_resp       = io_ddrA_r_payload_resp;
   assign m0_r_last       = io_ddrA_r_payload_last;
   assign m1_r_last       = io_ddrA_r_payload_last;

   assign b_sel           = io_ddrA_b_payload_id[ID_WIDTH-1];
   assign m0_b_valid      = resetn & io_ddrA_b_valid & ~b_sel;
   assign m1_b_valid      = resetn & io_ddrA_b_valid &  b_sel;
   assign io_ddrA_b_ready = resetn & (b_sel ? m1_b_ready : m0_b_ready);
   assign m0_b_id         = io_ddrA_b_payload_id[ID_WIDTH-2:0];
   assign m1_b_id         = io_ddrA_b_payload_id[ID_WIDTH-2:0];

   assign unused_bits = ^{sel_p.id, wq_count};
endmodule

// File: tb/tb_ddr_axi_arw_arbiter.sv
// tb_ddr_axi_arw_arbiter: directed self-checking bench for ddr_axi_arw_arbiter.
module tb_ddr_axi_arw_arbiter;
   localparam int IDW = 8;
   localparam int DW  = 128;

   logic io_memoryClk, resetn;
   logic m0_arw_valid, m0_arw_ready, m0_arw_write, m1_arw_valid, m1_arw_ready, m1_arw_write;
   logic [31:0] m0_arw_addr, m1_arw_addr;
   logic [IDW-2:0] m0_arw_id, m1_arw_id, m0_b_id, m1_b_id, m0_r_id, m1_r_id;
   logic [7:0] m0_arw_len, m1_arw_len;
   logic [2:0] m0_arw_size, m1_arw_size;
   logic [1:0] m0_arw_burst, m1_arw_burst, m0_arw_lock, m1_arw_lock, m0_r_resp, m1_r_resp;
   logic m0_w_valid, m0_w_ready, m0_w_last, m1_w_valid, m1_w_ready, m1_w_last;
   logic [DW-1:0] m0_w_data, m1_w_data, m0_r_data, m1_r_data;
   logic [DW/8-1:0] m0_w_strb, m1_w_strb;
   logic m0_b_valid, m0_b_ready, m1_b_valid, m1_b_ready;
   logic m0_r_valid, m0_r_ready, m0_r_last, m1_r_valid, m1_r_ready, m1_r_last;
   logic io_ddrA_arw_valid, io_ddrA_arw_ready, io_ddrA_arw_payload_write;
   logic [31:0] io_ddrA_arw_payload_addr;
   logic [IDW-1:0] io_ddrA_arw_payload_id, io_ddrA_w_payload_id, io_ddrA_b_payload_id, io_ddrA_r_payload_id;
   logic [7:0] io_ddrA_arw_payload_len;
   logic [2:0] io_ddrA_arw_payload_size;
   logic [1:0] io_ddrA_arw_payload_burst, io_ddrA_arw_payload_lock, io_ddrA_r_payload_resp;
   logic io_ddrA_w_valid, io_ddrA_w_ready, io_ddrA_w_payload_last;
   logic [DW-1:0] io_ddrA_w_payload_data, io_ddrA_r_payload_data;
   logic [DW/8-1:0] io_ddrA_w_payload_strb;
   logic io_ddrA_b_valid, io_ddrA_b_ready, io_ddrA_r_valid, io_ddrA_r_ready, io_ddrA_r_payload_last;

   int checks = 0;
   int errors = 0;

   ddr_axi_arw_arbiter #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .WQ_DEPTH(4)) dut (
      .io_memoryClk(io_memoryClk), .resetn(resetn),
      .m0_arw_valid(m0_arw_valid), .m0_arw_ready(m0_arw_ready), .m0_arw_addr(m0_arw_addr),
      .m0_arw_id(m0_arw_id), .m0_arw_len(m0_arw_len), .m0_arw_size(m0_arw_size),
      .m0_arw_burst(m0_arw_burst), .m0_arw_lock(m0_arw_lock), .m0_arw_write(m0_arw_write),
      .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready), .m0_w_data(m0_w_data),
      .m0_w_strb(m0_w_strb), .m0_w_last(m0_w_last),
      .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready), .m0_b_id(m0_b_id),
      .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_data(m0_r_data),
      .m0_r_id(m0_r_id), .m0_r_resp(m0_r_resp), .m0_r_last(m0_r_last),
      .m1_arw_valid(m1_arw_valid), .m1_arw_ready(m1_arw_ready), .m1_arw_addr(m1_arw_addr),
      .m1_arw_id(m1_arw_id), .m1_arw_len(m1_arw_len), .m1_arw_size(m1_arw_size),
      .m1_arw_burst(m1_arw_burst), .m1_arw_lock(m1_arw_lock), .m1_arw_write(m1_arw_write),
      .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready), .m1_w_data(m1_w_data),
      .m1_w_strb(m1_w_strb), .m1_w_last(m1_w_last),
      .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready), .m1_b_id(m1_b_id),
      .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_data(m1_r_data),
      .m1_r_id(m1_r_id), .m1_r_resp(m1_r_resp), .m1_r_last(m1_r_last),
      .io_ddrA_arw_valid(io_ddrA_arw_valid), .io_ddrA_arw_ready(io_ddrA_arw_ready),
      .io_ddrA_arw_payload_addr(io_ddrA_arw_payload_addr), .io_ddrA_arw_payload_id(io_ddrA_arw_payload_id),
      .io_ddrA_arw_payload_len(io_ddrA_arw_payload_len), .io_ddrA_arw_payload_size(io_ddrA_arw_payload_size),
      .io_ddrA_arw_payload_burst(io_ddrA_arw_payload_burst), .io_ddrA_arw_payload_lock(io_ddrA_arw_payload_lock),
      .io_ddrA_arw_payload_write(io_ddrA_arw_payload_write),
      .io_ddrA_w_valid(io_ddrA_w_valid), .io_ddrA_w_ready(io_ddrA_w_ready),
      .io_ddrA_w_payload_data(io_ddrA_w_payload_data), .io_ddrA_w_payload_strb(io_ddrA_w_payload_strb),
      .io_ddrA_w_payload_last(io_ddrA_w_payload_last), .io_ddrA_w_payload_id(io_ddrA_w_payload_id),
      .io_ddrA_b_valid(io_ddrA_b_valid), .io_ddrA_b_ready(io_ddrA_b_ready),
      .io_ddrA_b_payload_id(io_ddrA_b_payload_id),
      .io_ddrA_r_valid(io_ddrA_r_valid), .io_ddrA_r_ready(io_ddrA_r_ready),
      .io_ddrA_r_payload_data(io_ddrA_r_payload_data), .io_ddrA_r_payload_id(io_ddrA_r_payload_id),
      .io_ddrA_r_payload_resp(io_ddrA_r_payload_resp), .io_ddrA_r_payload_last(io_ddrA_r_payload_last)
   );

   initial io_memoryClk = 1'b0;
   always #5 io_memoryClk = ~io_memoryClk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge io_memoryClk);
      #1;
   endtask

   // waits for an ARW handshake (bounded), returns grant MSB and write flag, then steps past that edge
   task automatic wait_hs(input string name, output logic msb, output logic wr);
      logic got;
      got = 1'b0;
      msb = 1'b0;
      wr  = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge io_memoryClk);
         if (io_ddrA_arw_valid && io_ddrA_arw_ready) begin
            got = 1'b1;
            msb = io_ddrA_arw_payload_id[IDW-1];
            wr  = io_ddrA_arw_payload_write;
         end
      end
      check(name, 64'(got), 64'(1));
      if (got) tick();
   endtask

   typedef struct {
      logic rv; logic [7:0] rid; logic r0; logic r1;
      logic bv; logic [7:0] bid; logic b0; logic b1;
      logic e_m0rv; logic e_m1rv; logic [6:0] e_rid; logic e_rr;
      logic e_m0bv; logic e_m1bv; logic [6:0] e_bid; logic e_br;
   } route_t;

   route_t rt[5];
   logic   exp_g[8];
   logic   msb, wr;
   int     c0, c1;

   initial begin
      rt[0] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 7'h05, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0};
      rt[1] = '{1'b1, 8'h85, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 7'h05, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0};
      rt[2] = '{1'b0, 8'h7f, 1'b1, 1'b0, 1'b1, 8'h92, 1'b0, 1'b1, 1'b0, 1'b0, 7'h7f, 1'b1, 1'b0, 1'b1, 7'h12, 1'b1};
      rt[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 7'h12, 1'b1};
      rt[4] = '{1'b1, 8'hff, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 7'h7f, 1'b1, 1'b0, 1'b1, 7'h00, 1'b0};
`ifdef DDR_ARB_RR_EN
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

      resetn = 1'b0;
      m0_arw_valid = 0; m0_arw_addr = 0; m0_arw_id = 0; m0_arw_len = 0; m0_arw_size = 3'd4;
      m0_arw_burst = 2'd1; m0_arw_lock = 0; m0_arw_write = 0;
      m1_arw_valid = 0; m1_arw_addr = 0; m1_arw_id = 0; m1_arw_len = 0; m1_arw_size = 3'd4;
      m1_arw_burst = 2'd1; m1_arw_lock = 0; m1_arw_write = 0;
      m0_w_valid = 0; m0_w_data = 0; m0_w_strb = '1; m0_w_last = 0;
      m1_w_valid = 0; m1_w_data = 0; m1_w_strb = '1; m1_w_last = 0;
      m0_b_ready = 0; m1_b_ready = 0; m0_r_ready = 0; m1_r_ready = 0;
      io_ddrA_arw_ready = 1; io_ddrA_w_ready = 1;
      io_ddrA_b_valid = 0; io_ddrA_b_payload_id = 0;
      io_ddrA_r_valid = 0; io_ddrA_r_payload_id = 0; io_ddrA_r_payload_data = 0;
      io_ddrA_r_payload_resp = 0; io_ddrA_r_payload_last = 0;

      // reset state with live traffic on every input
      m0_arw_valid = 1; m0_w_valid = 1; io_ddrA_r_valid = 1; io_ddrA_r_payload_id = 8'h05;
      m0_r_ready = 1; io_ddrA_b_valid = 1; m0_b_ready = 1;
      #2;
      check("rst_arw_valid", 64'(io_ddrA_arw_valid), 64'(0));
      check("rst_w", 64'({io_ddrA_w_valid, m0_w_ready}), 64'(0));
      check("rst_r", 64'({m0_r_valid, m1_r_valid, io_ddrA_r_ready}), 64'(0));
      check("rst_b", 64'({m0_b_valid, m1_b_valid, io_ddrA_b_ready}), 64'(0));
      m0_arw_valid = 0; m0_w_valid = 0; io_ddrA_r_valid = 0; m0_r_ready = 0;
      io_ddrA_b_valid = 0; m0_b_ready = 0;
      repeat (2) tick();
      resetn = 1'b1;

      // R/B routing table
      for (int i = 0; i < 5; i++) begin
         io_ddrA_r_valid = rt[i].rv; io_ddrA_r_payload_id = rt[i].rid;
         m0_r_ready = rt[i].r0; m1_r_ready = rt[i].r1;
         io_ddrA_b_valid = rt[i].bv; io_ddrA_b_payload_id = rt[i].bid;
         m0_b_ready = rt[i].b0; m1_b_ready = rt[i].b1;
         #1;
         check($sformatf("route_r[%0d]", i), 64'({m0_r_valid, m1_r_valid, m0_r_id, m1_r_id, io_ddrA_r_ready}),
               64'({rt[i].e_m0rv, rt[i].e_m1rv, rt[i].e_rid, rt[i].e_rid, rt[i].e_rr}));
         check($sformatf("route_b[%0d]", i), 64'({m0_b_valid, m1_b_valid, m0_b_id, m1_b_id, io_ddrA_b_ready}),
               64'({rt[i].e_m0bv, rt[i].e_m1bv, rt[i].e_bid, rt[i].e_bid, rt[i].e_br}));
      end
      io_ddrA_r_valid = 0; io_ddrA_b_valid = 0;
      m0_r_ready = 0; m1_r_ready = 0; m0_b_ready = 0; m1_b_ready = 0;
      tick();

      // m0 read, one-cycle grant latency, R beats to m0 only
      m0_arw_valid = 1; m0_arw_addr = 32'h1000; m0_arw_id = 7'h05; m0_arw_len = 8'd3; m0_arw_write = 0;
      @(negedge io_memoryClk);
      check("a_arw_latency", 64'(io_ddrA_arw_valid), 64'(0));
      tick();
      check("a_arw_valid", 64'(io_ddrA_arw_valid), 64'(1));
      check("a_arw_payload", 64'({io_ddrA_arw_payload_addr, io_ddrA_arw_payload_id, io_ddrA_arw_payload_len, io_ddrA_arw_payload_write}),
            64'({32'h1000, 8'h05, 8'd3, 1'b0}));
      check("a_arw_ready", 64'({m0_arw_ready, m1_arw_ready}), 64'(2'b10));
      tick();
      m0_arw_valid = 0;
      check("a_idle_after_hs", 64'(io_ddrA_arw_valid), 64'(0));
      io_ddrA_r_valid = 1; io_ddrA_r_payload_id = 8'h05; io_ddrA_r_payload_data = 128'h1234_5678_9abc;
      m0_r_ready = 1;
      #1;
      check("a_r_route", 64'({m0_r_valid, m1_r_valid, m0_r_id, io_ddrA_r_ready}), 64'({1'b1, 1'b0, 7'h05, 1'b1}));
      check("a_r_data", 64'(m0_r_data), 64'h1234_5678_9abc);
      io_ddrA_r_valid = 0; m0_r_ready = 0;
      tick();

      // m1 write, ID extension and W from m1 only
      m1_arw_valid = 1; m1_arw_addr = 32'h2000; m1_arw_id = 7'h12; m1_arw_len = 8'd1; m1_arw_write = 1;
      tick();
      check("b_arw_id", 64'({io_ddrA_arw_payload_id, io_ddrA_arw_payload_write}), 64'({8'h92, 1'b1}));
      check("b_arw_ready", 64'({m0_arw_ready, m1_arw_ready}), 64'(2'b01));
      tick();
      m1_arw_valid = 0;
      m1_w_valid = 1; m1_w_data = 128'hA1; m1_w_last = 0;
      m0_w_valid = 1; m0_w_data = 128'hB0; m0_w_last = 1;
      #1;
      check("b_w_beat0", 64'({io_ddrA_w_valid, io_ddrA_w_payload_id, m1_w_ready, m0_w_ready, io_ddrA_w_payload_data[15:0]}),
            64'({1'b1, 8'h80, 1'b1, 1'b0, 16'h00A1}));
      tick();
      m1_w_data = 128'hA2; m1_w_last = 1;
      #1;
      check("b_w_beat1", 64'({io_ddrA_w_payload_last, io_ddrA_w_payload_data[15:0]}), 64'({1'b1, 16'h00A2}));
      tick();
      m1_w_valid = 0;
      #1;
      check("b_queue_empty", 64'({io_ddrA_w_valid, m0_w_ready, m1_w_ready}), 64'(0));
      m0_w_valid = 0; m0_w_last = 0;
      tick();

      // both masters request four reads each
      m0_arw_write = 0; m1_arw_write = 0; m0_arw_id = 7'h01; m1_arw_id = 7'h02;
      m0_arw_valid = 1; m1_arw_valid = 1; c0 = 0; c1 = 0;
      for (int k = 0; k < 8; k++) begin
         wait_hs($sformatf("c_hs[%0d]", k), msb, wr);
         check($sformatf("c_grant[%0d]", k), 64'(msb), 64'(exp_g[k]));
         if (msb) c1++; else c0++;
         if (c0 >= 4) m0_arw_valid = 0;
         if (c1 >= 4) m1_arw_valid = 0;
      end
      m0_arw_valid = 0; m1_arw_valid = 0;
      tick();

      // queue full: fifth write blocked, a read still passes
      m0_arw_write = 1; m0_arw_id = 7'h03; m0_arw_valid = 1;
      for (int k = 0; k < 4; k++) begin
         wait_hs($sformatf("d_hs[%0d]", k), msb, wr);
         check($sformatf("d_write[%0d]", k), 64'({msb, wr}), 64'(2'b01));
      end
      m1_arw_write = 0; m1_arw_id = 7'h04; m1_arw_valid = 1;
      wait_hs("d_read_hs", msb, wr);
      check("d_read_passes", 64'({msb, wr}), 64'(2'b10));
      m1_arw_valid = 0;
      repeat (3) @(negedge io_memoryClk);
      check("d_fifth_held", 64'(io_ddrA_arw_valid), 64'(0));
      tick();
      m0_w_valid = 1; m0_w_last = 1; m0_w_data = 128'hD0;
      tick();
      m0_w_valid = 0;
      wait_hs("d_fifth_hs", msb, wr);
      check("d_fifth_released", 64'({msb, wr}), 64'(2'b01));
      m0_arw_valid = 0;
      m0_w_valid = 1;
      repeat (4) tick();
      check("d_drained", 64'({io_ddrA_w_valid, m0_w_ready}), 64'(0));
      m0_w_valid = 0; m0_w_last = 0;
      tick();

      // W ordering: m1 presents data early but waits for m0's burst
      m1_w_valid = 1; m1_w_data = 128'hC1; m1_w_last = 1;
      m0_arw_id = 7'h06; m0_arw_write = 1; m0_arw_valid = 1;
      wait_hs("e_m0_hs", msb, wr);
      m0_arw_valid = 0;
      m1_arw_id = 7'h07; m1_arw_write = 1; m1_arw_valid = 1;
      wait_hs("e_m1_hs", msb, wr);
      m1_arw_valid = 0;
      check("e_m1_waits", 64'({m1_w_ready, io_ddrA_w_valid}), 64'(0));
      m0_w_valid = 1; m0_w_data = 128'hE1; m0_w_last = 0;
      #1;
      check("e_m0_beat0", 64'({m0_w_ready, m1_w_ready, io_ddrA_w_payload_data[15:0]}), 64'({1'b1, 1'b0, 16'h00E1}));
      tick();
      m0_w_data = 128'hE2; m0_w_last = 1;
      #1;
      check("e_m0_last", 64'({m0_w_ready, m1_w_ready, io_ddrA_w_payload_data[15:0]}), 64'({1'b1, 1'b0, 16'h00E2}));
      tick();
      m0_w_valid = 0; m0_w_last = 0;
      #1;
      check("e_m1_turn", 64'({m0_w_ready, m1_w_ready, io_ddrA_w_payload_id, io_ddrA_w_payload_data[15:0]}),
            64'({1'b0, 1'b1, 8'h80, 16'h00C1}));
      tick();
      m1_w_valid = 0; m1_w_last = 0;
      #1;
      check("e_done", 64'(io_ddrA_w_valid), 64'(0));
      tick();

      // reset during BUSY with a W burst half done
      m0_arw_id = 7'h08; m0_arw_write = 1; m0_arw_valid = 1;
      wait_hs("f_w_hs", msb, wr);
      m0_arw_valid = 0;
      m0_w_valid = 1; m0_w_last = 0;
      tick();
      io_ddrA_arw_ready = 0;
      m1_arw_write = 0; m1_arw_id = 7'h09; m1_arw_valid = 1;
      tick();
      check("f_busy", 64'({io_ddrA_arw_valid, io_ddrA_w_valid}), 64'(2'b11));
      io_ddrA_r_valid = 1; io_ddrA_r_payload_id = 8'h05; m0_r_ready = 1;
      io_ddrA_b_valid = 1; io_ddrA_b_payload_id = 8'h85; m1_b_ready = 1;
      #2;
      resetn = 1'b0;
      #1;
      check("f_reset_outputs", 64'({io_ddrA_arw_valid, io_ddrA_w_valid, m0_w_ready, m1_arw_ready, m0_r_valid,
            m1_r_valid, m0_b_valid, m1_b_valid, io_ddrA_r_ready, io_ddrA_b_ready}), 64'(0));
      m1_arw_valid = 0; io_ddrA_arw_ready = 1;
      io_ddrA_r_valid = 0; m0_r_ready = 0; io_ddrA_b_valid = 0; m1_b_ready = 0;
      tick();
      resetn = 1'b1;
      #1;
      check("f_post_idle", 64'(io_ddrA_arw_valid), 64'(0));
      check("f_post_queue_empty", 64'({io_ddrA_w_valid, m0_w_ready}), 64'(0));
      m0_w_valid = 0;
      tick();
      m1_arw_valid = 1;
      wait_hs("f_new_hs", msb, wr);
      check("f_new_grant", 64'({msb, wr}), 64'(2'b10));
      m1_arw_valid = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ddr_axi_arw_arbiter.md
# ddr_axi_arw_arbiter

Two-master arbiter that shares the single combined-address-channel AXI port (`io_ddrA_*`: one ARW channel with a write flag, plus W, B and R) between two requesters. Typical requesters are the SoC DDR master and the DMA. It sits between the requesters and the external memory controller in the memory clock domain. The block does three things:
- arbitrates ARW;
- keeps W data in the same order as the write addresses it granted;
- routes R and B responses back to the issuing master using the ID MSB.

## Interface
Parameters:
- `ID_WIDTH`, 8: slave-side ID width. Masters use `ID_WIDTH-1` bits.
- `DATA_WIDTH`, 128: W/R data width. Strobe width is `DATA_WIDTH/8`.
- `WQ_DEPTH`, 4: write-order queue depth. Must be a power of 2, ≥2.

Ports (`mN` = `m0`, `m1`):
- `io_memoryClk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `mN_arw_valid` / `mN_arw_ready`  in / out  1  master address handshake.
- `mN_arw_addr`, `mN_arw_id`, `mN_arw_len`, `mN_arw_size`, `mN_arw_burst`, `mN_arw_lock`, `mN_arw_write`  in  32, `ID_WIDTH-1`, 8, 3, 2, 2, 1  master address payload.
- `mN_w_valid`, `mN_w_data`, `mN_w_strb`, `mN_w_last`  in  1, `DATA_WIDTH`, `DATA_WIDTH/8`, 1; `mN_w_ready`  out  1.
- `mN_b_valid`, `mN_b_id`  out  1, `ID_WIDTH-1`; `mN_b_ready`  in  1.
- `mN_r_valid`, `mN_r_data`, `mN_r_id`, `mN_r_resp`, `mN_r_last`  out; `mN_r_ready`  in  1.
- `io_ddrA_arw_*`, `io_ddrA_w_*`, `io_ddrA_b_*`, `io_ddrA_r_*`: slave side. Same widths as the memory port (ID `ID_WIDTH`). `io_ddrA_w_payload_id` is driven too.

## Operation
- Arbiter FSM, two states:
  - **IDLE**: if any eligible master has `arw_valid` high, register the winner in `gnt` and go to **BUSY**.
  - **BUSY**: drive `io_ddrA_arw_valid` = 1 with the winner's payload. Go back to IDLE on `io_ddrA_arw_ready`.
- The grant is held until the handshake completes, so the AXI payload stays stable.
- `mN_arw_ready` = `io_ddrA_arw_ready` & BUSY & (`gnt`==N).
- Output ID = {`gnt`, `mN_arw_id`}. `io_ddrA_w_payload_id` = {head, 0}.
- Eligibility: a write request is eligible only if the write-order queue is not full. A read request is always eligible.
- Write-order queue (FIFO of 1-bit master index):
  - Push `gnt` on an ARW handshake with `write`=1.
  - Pop on a W handshake with `last`=1.
  - A simultaneous push and pop is legal and leaves the count unchanged.
- W mux: when the queue is not empty, `io_ddrA_w_*` are taken from the master at the queue head and only that master sees `w_ready`. When the queue is empty, `io_ddrA_w_valid`=0 and every `mN_w_ready`=0.
- R/B routing: the response ID MSB selects the master. The low bits pass through as `mN_*_id`. `io_ddrA_r_ready` / `io_ddrA_b_ready` come from the selected master. The non-selected master sees valid=0.

## Timing
- ARW: request to `io_ddrA_arw_valid` takes 1 cycle (registered grant). Back-to-back grants need one IDLE cycle, so peak throughput is 1 address per 2 cycles.
- W/R/B paths are combinational with zero latency.
- A master may present W data before its address has been granted. That data waits until the master is at the queue head.
- Reset, whether at power-up or mid-burst:
  - The FSM goes to IDLE, the queue is cleared, `gnt`=0 and the priority pointer is 0.
  - All valid outputs and ready outputs on the slave side are 0 while `resetn`=0. Payload outputs are don't-care.
  - Reset is asserted asynchronously and released synchronously to `io_memoryClk` by the upstream reset logic.

## Configuration
- `DDR_ARB_RR_EN` defined: round-robin arbitration. After each ARW handshake the pointer moves to the other master. On a tie, the master the pointer selects wins.
- `DDR_ARB_RR_EN` undefined: fixed priority, `m0` over `m1`. The pointer logic is removed.

## Structure
- Shared package `ddr_arb_pkg`: the FSM state enum (IDLE, BUSY), `ARB_IDX_W`=1, and the ARW payload struct (addr, id, len, size, burst, lock, write).
- Sub-module `ddr_arb_order_fifo`: the parameterised 1-bit sync FIFO with full, empty and count outputs, used for the write-order queue.

## Test plan
- `m0` read, len=3, addr 0x1000, id 0x05: slave sees id 0x05 one cycle after valid. R beats with id 0x05 go only to `m0`.
- `m1` write, len=1, id 0x12: slave ARW id = 0x92. Both W beats come from `m1`. B with id 0x92 reaches `m1` as 0x12.
- Both masters hold `arw_valid` for 4 requests each:
  - with `DDR_ARB_RR_EN`, grants are m0, m1, m0, m1, …;
  - without it, all four `m0` grants come first.
- Five writes issued with `WQ_DEPTH`=4 and W withheld: the fifth write gets no grant while a read from the other master is still granted. Completing one W burst releases the fifth write.
- A write from `m0` followed by a write from `m1`, with `m1` presenting W first: `m1_w_ready` stays 0 until `m0` W `last` has handshaken.
- `resetn` pulled low during BUSY with a W burst half done: all valid outputs are 0 immediately. After release the FSM is IDLE, the queue is empty, and a new request completes.
